// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle 16-bit datapath: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables, with memory states stalled on the mem_ready handshake.
module multicycle_control #(
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNE,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_ALU_WB    = 4'd7,
    S_EXEC_I    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_HALT      = 4'd11
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_op_q;

  logic       w_pc_write, w_pc_write_cond, w_branch_ne, w_iord, w_mem_read, w_mem_write;
  logic       w_ir_write, w_mem_to_reg, w_reg_write, w_reg_dst, w_alu_src_a, w_illegal;
  logic [1:0] w_alu_src_b, w_pc_source;
  logic [2:0] w_alu_op, w_alu_op_exec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_op_q  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op_q <= opcode;
    end
  end

  // ALU operation selected by the latched opcode; ALU_WB reuses it so ALUOp holds across writeback.
  always_comb begin
    w_alu_op_exec = 3'd2;
    case (r_op_q)
      4'd0:    w_alu_op_exec = 3'd0;
      4'd1:    w_alu_op_exec = 3'd1;
      4'd3:    w_alu_op_exec = 3'd4;
      4'd4:    w_alu_op_exec = 3'd5;
      4'd5:    w_alu_op_exec = 3'd6;
      default: w_alu_op_exec = 3'd2;
    endcase
  end

  always_comb begin
    w_next          = r_state;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_branch_ne     = 1'b0;
    w_iord          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_reg_write     = 1'b0;
    w_reg_dst       = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = 2'b00;
    w_pc_source     = 2'b00;
    w_alu_op        = 3'd0;
    w_illegal       = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
        w_alu_op    = 3'd2;
        w_ir_write  = mem_ready;
        w_pc_write  = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_alu_src_b = 2'b11;
        w_alu_op    = 3'd2;
        case (opcode)
          4'd0, 4'd1:             w_next = S_EXEC_R;
          4'd2, 4'd3, 4'd4, 4'd5: w_next = S_EXEC_I;
          4'd6, 4'd7:             w_next = S_MEM_ADDR;
          4'd8, 4'd9:             w_next = S_BRANCH;
          4'hA:                   w_next = S_JUMP;
          HALT_OP:                w_next = S_HALT;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_alu_op    = 3'd2;
        w_next      = (r_op_q == 4'd6) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        w_iord     = 1'b1;
        w_mem_read = 1'b1;
        if (mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEM_WRITE: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXEC_R: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = w_alu_op_exec;
        w_next      = S_ALU_WB;
      end
      S_ALU_WB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = (r_op_q <= 4'd1);
        w_alu_op    = w_alu_op_exec;
        w_next      = S_FETCH;
      end
      S_EXEC_I: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_alu_op    = w_alu_op_exec;
        w_next      = S_ALU_WB;
      end
      S_BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = 3'd3;
        w_pc_write_cond = 1'b1;
        w_pc_source     = 2'b01;
        w_branch_ne     = (r_op_q == 4'd9);
        w_next          = S_FETCH;
      end
      S_JUMP: begin
        w_pc_write  = 1'b1;
        w_pc_source = 2'b10;
        w_next      = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  // Outputs are forced low while reset is held, including the FETCH strobes.
  assign PCWrite     = w_pc_write      & ~reset;
  assign PCWriteCond = w_pc_write_cond & ~reset;
  assign BranchNE    = w_branch_ne     & ~reset;
  assign IorD        = w_iord          & ~reset;
  assign MemRead     = w_mem_read      & ~reset;
  assign MemWrite    = w_mem_write     & ~reset;
  assign IRWrite     = w_ir_write      & ~reset;
  assign MemtoReg    = w_mem_to_reg    & ~reset;
  assign RegWrite    = w_reg_write     & ~reset;
  assign RegDst      = w_reg_dst       & ~reset;
  assign ALUSrcA     = w_alu_src_a     & ~reset;
  assign ALUSrcB     = reset ? '0 : w_alu_src_b;
  assign PCSource    = reset ? '0 : w_pc_source;
  assign ALUOp       = reset ? '0 : w_alu_op;
  assign illegal_op  = w_illegal       & ~reset;
  assign state       = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed and randomized instructions checked cycle by cycle
// against a per-instruction state path and per-state output table.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegWrite, RegDst, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [3:0] state;

  int n_chk  = 0;
  int n_fail = 0;
  int path[$];

  multicycle_control #(.HALT_OP(4'hF)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALUOp(ALUOp), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  logic [18:0] obs;
  assign obs = {PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp, illegal_op};

  // Expected output bundle for a state, the instruction's opcode and this cycle's mem_ready.
  function automatic logic [18:0] exp_out(input int st, input int op, input logic mr);
    logic pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rw, rd, srca, ilg;
    logic [1:0] srcb, pcs;
    logic [2:0] aop;
    int alu_tab [0:5] = '{0, 1, 2, 4, 5, 6};
    {pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rw, rd, srca, ilg} = '0;
    srcb = 2'b00; pcs = 2'b00; aop = 3'd0;
    case (st)
      0:  begin mrd = 1; srcb = 2'b01; aop = 3'd2; irw = mr; pcw = mr; end
      1:  begin srcb = 2'b11; aop = 3'd2; ilg = (op >= 11 && op <= 14); end
      2:  begin srca = 1; srcb = 2'b10; aop = 3'd2; end
      3:  begin iord = 1; mrd = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin iord = 1; mwr = 1; end
      6:  begin srca = 1; aop = (op == 1) ? 3'd1 : 3'd0; end
      7:  begin rw = 1; rd = (op <= 1); aop = 3'(alu_tab[op]); end
      8:  begin srca = 1; srcb = 2'b10; aop = 3'(alu_tab[op]); end
      9:  begin srca = 1; aop = 3'd3; pcwc = 1; pcs = 2'b01; bne = (op == 9); end
      10: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rw, rd, srca, srcb, pcs, aop, ilg};
  endfunction

  task automatic build_path(input int op);
    path = '{0, 1};
    if (op <= 1)                 path.push_back(6);
    else if (op <= 5)            path.push_back(8);
    else if (op == 6)            path = {path, 2, 3, 4};
    else if (op == 7)            path = {path, 2, 5};
    else if (op == 8 || op == 9) path.push_back(9);
    else if (op == 10)           path.push_back(10);
    else if (op == 15)           path.push_back(11);
    if (op <= 5) path.push_back(7);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    assert (got === want)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    opcode = 4'($urandom_range(0, 15));
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_outputs", 32'(obs), 32'd0);
    @(negedge clk);
    #1;
    chk("reset_held_state", 32'(state), 32'd0);
    chk("reset_held_outputs", 32'(obs), 32'd0);
  endtask

  // Walks one instruction; fwait/mwait stall FETCH and the memory states, abort_cyc returns early.
  task automatic run_instr(input int op, input int fwait, input int mwait,
                           input int abort_cyc, input int halt_cycles);
    int cyc = 0;
    build_path(op);
    foreach (path[i]) begin
      int st = path[i];
      int w  = 0;
      forever begin
        logic is_wait;
        @(negedge clk);
        cyc++;
        reset  = 1'b0;
        opcode = (st == 1) ? 4'(op) : 4'($urandom_range(0, 15));
        is_wait = (st == 0 && w < fwait) || ((st == 3 || st == 5) && w < mwait);
        mem_ready = (st == 0 || st == 3 || st == 5) ? !is_wait : 1'($urandom_range(0, 1));
        #1;
        chk($sformatf("state op%0h", op), 32'(state), 32'(st));
        chk($sformatf("outputs op%0h st%0d", op, st), 32'(obs), 32'(exp_out(st, op, mem_ready)));
        chk("rd_wr_exclusive", 32'(MemRead & MemWrite), 32'd0);
        if (abort_cyc != 0 && cyc == abort_cyc) return;
        if (st == 11) begin
          if (w + 1 >= halt_cycles) break;
        end else if (!is_wait) break;
        w++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b0;
    opcode = 4'd0;
    do_reset();
    run_instr(0, 0, 0, 0, 0);
    run_instr(6, 0, 3, 0, 0);
    run_instr(9, 0, 0, 0, 0);
    run_instr(8, 0, 0, 0, 0);
    run_instr(4'hC, 0, 0, 0, 0);
    run_instr(7, 0, 5, 5, 0);
    do_reset();
    run_instr(7, 1, 1, 0, 0);
    run_instr(4'hA, 2, 0, 0, 0);
    run_instr(4'hF, 0, 0, 0, 20);
    do_reset();
    for (int n = 0; n < 60; n++) begin
      int op = $urandom_range(0, 15);
      int fw = $urandom_range(0, 2);
      int mw = $urandom_range(0, 3);
      if (op == 15) begin
        run_instr(op, fw, mw, 0, 5);
        do_reset();
      end else if (op == 7 && mw >= 1 && $urandom_range(0, 1) == 1) begin
        run_instr(op, fw, mw, fw + 4, 0);
        do_reset();
      end else begin
        run_instr(op, fw, mw, 0, 0);
      end
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
